// File: rtl/uart_ram_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_ram_loader: 8N1 UART receiver that packs bytes into RAM write words.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_ram_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int WORD_BYTES   = 4,
    parameter int ADDR_WIDTH   = 12,
    parameter int BIG_ENDIAN   = 1,
    parameter int TIMEOUT_CLKS = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    serialIn,
    input  logic                    setAddr,
    input  logic [ADDR_WIDTH-1:0]   startAddr,
    output logic                    writeEnable,
    output logic [ADDR_WIDTH-1:0]   writeAddr,
    output logic [8*WORD_BYTES-1:0] writeData,
    output logic [7:0]              lastByte,
    output logic                    byteValid,
    output logic                    err,
    output logic                    busy
);

    localparam int c_word_w = 8 * WORD_BYTES;
    localparam int c_cnt_w  = $clog2(CLKS_PER_BIT);
    localparam int c_idx_w  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int c_to_w   = (TIMEOUT_CLKS > 0) ? $clog2(TIMEOUT_CLKS + 1) : 1;

    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(WORD_BYTES - 1);
    localparam logic [c_to_w-1:0]  c_to_last   = c_to_w'(TIMEOUT_CLKS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync2_q;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic [2:0]           bitcnt_q, bitcnt_d;
    logic [7:0]           rxsh_q, rxsh_d;
    logic [c_idx_w-1:0]   idx_q, idx_d;
    logic [c_word_w-1:0]  word_q, word_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [c_to_w-1:0]    idle_q, idle_d;
    logic                 we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [c_word_w-1:0]  wdata_q, wdata_d;
    logic [7:0]           last_q;
    logic                 bv_q;
    logic                 err_q, err_d;

    logic                 w_accept;
    logic                 w_frame_err;
    logic                 w_flush;
    logic [c_idx_w-1:0]   w_slot;
    logic [c_word_w-1:0]  w_ins;

    // Receive FSM: all bit timing is relative to the synchronized line.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bitcnt_d    = bitcnt_q;
        rxsh_d      = rxsh_q;
        w_accept    = 1'b0;
        w_frame_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!sync2_q) begin
                    state_d  = S_START;
                    cnt_d    = '0;
                    bitcnt_d = '0;
                end
            end
            S_START: begin
                if (cnt_q == c_half_last) begin
                    cnt_d   = '0;
                    state_d = sync2_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == c_bit_last) begin
                    cnt_d    = '0;
                    rxsh_d   = {sync2_q, rxsh_q[7:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == c_bit_last) begin
                    cnt_d       = '0;
                    state_d     = S_IDLE;
                    w_accept    = sync2_q;
                    w_frame_err = !sync2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign w_slot  = (BIG_ENDIAN != 0) ? (c_idx_last - idx_q) : idx_q;
    assign w_ins   = word_q | (c_word_w'(rxsh_q) << {w_slot, 3'b000});
    // An accepted byte restarts the idle window, so it beats a coincident flush.
    assign w_flush = (TIMEOUT_CLKS != 0) && (idx_q != '0) && (idle_q == c_to_last) && !w_accept;

    always_comb begin
        idx_d   = idx_q;
        word_d  = word_q;
        addr_d  = addr_q;
        idle_d  = idle_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        err_d   = err_q | w_frame_err;
        if (setAddr) begin
            addr_d = startAddr;
            idx_d  = '0;
            word_d = '0;
            idle_d = '0;
            err_d  = 1'b0;
        end else if (w_accept) begin
            idle_d = '0;
            if (idx_q == c_idx_last) begin
                we_d    = 1'b1;
                waddr_d = addr_q;
                wdata_d = w_ins;
                addr_d  = addr_q + 1'b1;
                idx_d   = '0;
                word_d  = '0;
            end else begin
                idx_d  = idx_q + 1'b1;
                word_d = w_ins;
            end
        end else if (w_flush) begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = word_q;
            addr_d  = addr_q + 1'b1;
            idx_d   = '0;
            word_d  = '0;
            idle_d  = '0;
        end else if ((TIMEOUT_CLKS != 0) && (idx_q != '0)) begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            rxsh_q   <= '0;
            idx_q    <= '0;
            word_q   <= '0;
            addr_q   <= '0;
            idle_q   <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            last_q   <= '0;
            bv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sync1_q  <= serialIn;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            rxsh_q   <= rxsh_d;
            idx_q    <= idx_d;
            word_q   <= word_d;
            addr_q   <= addr_d;
            idle_q   <= idle_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            bv_q     <= w_accept;
            if (w_accept) begin
                last_q <= rxsh_q;
            end
            err_q    <= err_d;
        end
    end

    assign writeEnable = we_q;
    assign writeAddr   = waddr_q;
    assign writeData   = wdata_q;
    assign lastByte    = last_q;
    assign byteValid   = bv_q;
    assign err         = err_q;
    assign busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_ram_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_ram_loader: scoreboard bench driving two loader configurations.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_uart_ram_loader;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        serialIn;
    logic        setAddr;
    logic [11:0] startAddr;

    logic        we0, bv0, err0, busy0;
    logic [11:0] waddr0;
    logic [31:0] wdata0;
    logic [7:0]  lb0;
    logic        we1, bv1, err1, busy1;
    logic [11:0] waddr1;
    logic [15:0] wdata1;
    logic [7:0]  lb1;

    always #5 clk = ~clk;

    // Instance 0: 32-bit big-endian words, idle flush longer than any frame gap.
    uart_ram_loader #(.CLKS_PER_BIT(CPB), .WORD_BYTES(4), .ADDR_WIDTH(12),
                      .BIG_ENDIAN(1), .TIMEOUT_CLKS(1000)) u0 (
        .clk(clk), .reset(reset), .serialIn(serialIn), .setAddr(setAddr),
        .startAddr(startAddr), .writeEnable(we0), .writeAddr(waddr0),
        .writeData(wdata0), .lastByte(lb0), .byteValid(bv0), .err(err0), .busy(busy0));

    // Instance 1: 16-bit little-endian words, flushing disabled.
    uart_ram_loader #(.CLKS_PER_BIT(CPB), .WORD_BYTES(2), .ADDR_WIDTH(12),
                      .BIG_ENDIAN(0), .TIMEOUT_CLKS(0)) u1 (
        .clk(clk), .reset(reset), .serialIn(serialIn), .setAddr(setAddr),
        .startAddr(startAddr), .writeEnable(we1), .writeAddr(waddr1),
        .writeData(wdata1), .lastByte(lb1), .byteValid(bv1), .err(err1), .busy(busy1));

    typedef struct packed {
        logic [11:0] a;
        logic [63:0] d;
    } wr_t;

    wr_t         q0[$];
    wr_t         q1[$];
    logic [7:0]  qb0[$];
    logic [7:0]  qb1[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model: per-instance list of bytes collected for the current word.
    logic [7:0]  m_bytes[2][8];
    int          m_cnt[2];
    logic [11:0] m_addr[2];
    logic        m_err;

    function automatic int cfg_wb(int k);   return (k == 0) ? 4 : 2;    endfunction
    function automatic int cfg_be(int k);   return (k == 0) ? 1 : 0;    endfunction
    function automatic int cfg_to(int k);   return (k == 0) ? 1000 : 0; endfunction

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void m_emit(int k);
        logic [63:0] d;
        logic [7:0]  b;
        int          pos;
        wr_t         w;
        d = '0;
        for (int i = 0; i < cfg_wb(k); i++) begin
            b   = (i < m_cnt[k]) ? m_bytes[k][i] : 8'h00;
            pos = (cfg_be(k) != 0) ? (cfg_wb(k) - 1 - i) : i;
            d   = d | (64'(b) << (8 * pos));
        end
        w.a = m_addr[k];
        w.d = d;
        if (k == 0) q0.push_back(w);
        else        q1.push_back(w);
        m_addr[k] = m_addr[k] + 12'd1;
        m_cnt[k]  = 0;
    endfunction

    function automatic void m_byte(logic [7:0] b);
        qb0.push_back(b);
        qb1.push_back(b);
        for (int k = 0; k < 2; k++) begin
            m_bytes[k][m_cnt[k]] = b;
            m_cnt[k]++;
            if (m_cnt[k] == cfg_wb(k)) m_emit(k);
        end
    endfunction

    function automatic void m_idle_long();
        for (int k = 0; k < 2; k++) begin
            if (cfg_to(k) > 0 && m_cnt[k] != 0) m_emit(k);
        end
    endfunction

    function automatic void m_set(logic [11:0] a);
        for (int k = 0; k < 2; k++) begin
            m_addr[k] = a;
            m_cnt[k]  = 0;
        end
        m_err = 1'b0;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        serialIn = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            serialIn = b[i];
            tick(CPB);
        end
        serialIn = stop;
        tick(CPB);
        serialIn = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] b);
        m_byte(b);
        send_frame(b, 1'b1);
    endtask

    task automatic send_bad();
        m_err = 1'b1;
        send_frame(8'h55, 1'b0);
        tick(20);
    endtask

    task automatic set_addr(input logic [11:0] a);
        m_set(a);
        startAddr = a;
        setAddr   = 1'b1;
        tick(1);
        setAddr   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_we"},    {63'd0, we0},   64'd0);
        check({tag, "_waddr"}, {52'd0, waddr0}, 64'd0);
        check({tag, "_wdata"}, {32'd0, wdata0}, 64'd0);
        check({tag, "_last"},  {56'd0, lb0},   64'd0);
        check({tag, "_bv"},    {63'd0, bv0},   64'd0);
        check({tag, "_err"},   {63'd0, err0},  64'd0);
        check({tag, "_busy"},  {63'd0, busy0}, 64'd0);
        check({tag, "_wdata1"}, {48'd0, wdata1}, 64'd0);
    endtask

    // Monitor: every DUT output event is matched against the expectation queues.
    wr_t        mon_w;
    logic [7:0] mon_b;
    always @(negedge clk) begin
        if (we0) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL wr0_unexpected: got write %0h@%0h expected none", wdata0, waddr0);
            end else begin
                mon_w = q0.pop_front();
                check("wr0_addr", {52'd0, waddr0}, {52'd0, mon_w.a});
                check("wr0_data", {32'd0, wdata0}, {32'd0, mon_w.d[31:0]});
            end
        end
        if (we1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL wr1_unexpected: got write %0h@%0h expected none", wdata1, waddr1);
            end else begin
                mon_w = q1.pop_front();
                check("wr1_addr", {52'd0, waddr1}, {52'd0, mon_w.a});
                check("wr1_data", {48'd0, wdata1}, {48'd0, mon_w.d[15:0]});
            end
        end
        if (bv0) begin
            if (qb0.size() == 0) begin
                checks++; errors++;
                $display("FAIL bv0_unexpected: got byte %0h expected none", lb0);
            end else begin
                mon_b = qb0.pop_front();
                check("byte0", {56'd0, lb0}, {56'd0, mon_b});
            end
        end
        if (bv1) begin
            if (qb1.size() == 0) begin
                checks++; errors++;
                $display("FAIL bv1_unexpected: got byte %0h expected none", lb1);
            end else begin
                mon_b = qb1.pop_front();
                check("byte1", {56'd0, lb1}, {56'd0, mon_b});
            end
        end
    end

    initial begin
        logic       prev_bad;
        logic [7:0] rb;
        int         r;

        reset     = 1'b1;
        serialIn  = 1'b1;
        setAddr   = 1'b0;
        startAddr = '0;
        m_set(12'h000);
        tick(3);
        check_reset_outputs("rst");
        reset = 1'b0;
        tick(5);

        // Big-endian packing into 0x010, then the next word lands at 0x011.
        set_addr(12'h010);
        send_good(8'hDE); send_good(8'hAD); send_good(8'hBE); send_good(8'hEF);
        tick(5);
        check("be_word", {32'd0, wdata0}, 64'hDEADBEEF);
        check("be_addr", {52'd0, waddr0}, 64'h010);
        check("le16_word", {48'd0, wdata1}, 64'hEFBE);
        check("le16_addr", {52'd0, waddr1}, 64'h011);
        send_good(8'h01); send_good(8'h02); send_good(8'h03); send_good(8'h04);
        tick(5);

        // Framing error in the middle of a word leaves the packer alone.
        send_good(8'h11); send_good(8'h22);
        send_bad();
        check("err_set0", {63'd0, err0}, 64'd1);
        check("err_set1", {63'd0, err1}, 64'd1);
        send_good(8'h33); send_good(8'h44);
        tick(5);
        check("err_sticky", {63'd0, err0}, 64'd1);
        set_addr(12'h100);
        tick(1);
        check("err_clear", {63'd0, err0}, 64'd0);

        // False start: 4 low clocks.
        serialIn = 1'b0;
        tick(4);
        serialIn = 1'b1;
        @(negedge clk);
        check("fs_busy_hi", {63'd0, busy0}, 64'd1);
        tick(20);
        check("fs_busy_lo0", {63'd0, busy0}, 64'd0);
        check("fs_busy_lo1", {63'd0, busy1}, 64'd0);

        // Address wrap from 0xFFF.
        set_addr(12'hFFF);
        for (int i = 0; i < 8; i++) send_good(8'($urandom_range(0, 255)));
        tick(5);
        check("wrap_addr", {52'd0, waddr0}, 64'h000);

        // setAddr held across the completing byte's acceptance discards the word.
        set_addr(12'h200);
        send_good(8'hA1); send_good(8'hA2); send_good(8'hA3);
        qb0.push_back(8'hA4);
        qb1.push_back(8'hA4);
        fork
            send_frame(8'hA4, 1'b1);
            begin
                tick(151);
                startAddr = 12'h345;
                setAddr   = 1'b1;
                tick(6);
                setAddr   = 1'b0;
            end
        join
        m_set(12'h345);
        send_good(8'h5A); send_good(8'h6B); send_good(8'h7C); send_good(8'h8D);
        tick(5);
        check("race_addr", {52'd0, waddr0}, 64'h345);
        check("race_data", {32'd0, wdata0}, 64'h5A6B7C8D);

        // Partial word flushed after idle timeout.
        set_addr(12'h020);
        send_good(8'h12); send_good(8'h34);
        m_idle_long();
        tick(1300);
        check("flush_data", {32'd0, wdata0}, 64'h12340000);
        check("flush_addr", {52'd0, waddr0}, 64'h020);

        // Randomized traffic: bytes, bad frames, address loads and idle gaps.
        prev_bad = 1'b0;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 99);
            if (r < 6) begin
                set_addr(12'($urandom_range(0, 4095)));
                prev_bad = 1'b0;
            end else if (r < 12 && !prev_bad) begin
                send_bad();
                prev_bad = 1'b1;
            end else begin
                rb = 8'($urandom_range(0, 255));
                send_good(rb);
                prev_bad = 1'b0;
            end
            if ($urandom_range(0, 99) < 12) begin
                m_idle_long();
                tick(1300);
            end else begin
                tick($urandom_range(0, 30));
            end
            check("rand_err", {63'd0, err0}, {63'd0, m_err});
        end
        m_idle_long();
        tick(1300);

        // Reset during the third byte of a word aborts everything.
        set_addr(12'h050);
        send_good(8'hC1); send_good(8'hC2);
        serialIn = 1'b0;
        tick(CPB);
        serialIn = 1'b1;
        tick(30);
        reset = 1'b1;
        tick(3);
        check_reset_outputs("midrst");
        reset = 1'b0;
        m_set(12'h000);
        tick(1300);
        check("post_rst_q0", q0.size(), 64'd0);
        send_good(8'hF0); send_good(8'hF1); send_good(8'hF2); send_good(8'hF3);
        tick(5);
        check("post_rst_addr", {52'd0, waddr0}, 64'h000);
        check("post_rst_data", {32'd0, wdata0}, 64'hF0F1F2F3);

        tick(20);
        check("q0_left", q0.size(), 64'd0);
        check("q1_left", q1.size(), 64'd0);
        check("qb0_left", qb0.size(), 64'd0);
        check("qb1_left", qb1.size(), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_ram_loader.md
# uart_ram_loader

Parametrised serial-to-RAM loader. Receives 8N1 UART bytes on `serialIn`, packs them into `8*WORD_BYTES`-bit words in a configurable byte order, and writes each completed word into data RAM through RAM's second write port (`wEn2`/`addr2`/`dataIn2`) at an auto-incrementing address. It sits beside `MemoryMap`: the processor sets the load address through `setAddr`/`startAddr` and polls `err`/`lastByte`. Added over the earlier fixed-width receiver: configurable word width and byte order, address wrap, false-start rejection, and partial-word timeout flush.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868: clk cycles per UART bit (100 MHz / 115200 baud); must be ≥ 4.
- `WORD_BYTES`, 4: bytes packed per RAM word, 1..8.
- `ADDR_WIDTH`, 12: RAM word-address width.
- `BIG_ENDIAN`, 1: 1 = first received byte goes to the MS byte; 0 = first byte goes to the LS byte.
- `TIMEOUT_CLKS`, 0: idle clocks after which a partial word is flushed; 0 disables flushing.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `serialIn`  in  1: asynchronous UART line, idles high.
- `setAddr`  in  1: one-cycle load strobe.
- `startAddr`  in  ADDR_WIDTH: address loaded on `setAddr`.
- `writeEnable`  out  1: one-cycle RAM write strobe.
- `writeAddr`  out  ADDR_WIDTH: RAM word address, valid while `writeEnable` is high.
- `writeData`  out  8*WORD_BYTES: packed word, valid while `writeEnable` is high.
- `lastByte`  out  8: last correctly framed byte.
- `byteValid`  out  1: one-cycle pulse when `lastByte` updates.
- `err`  out  1: sticky framing-error flag.
- `busy`  out  1: high while the receive FSM is outside IDLE.

## Operation
- Input path: `serialIn` passes through a 2-FF synchronizer. Both flops reset to 1.
- RX FSM:
  - IDLE: a synchronized 0 moves to START and clears the bit counter.
  - START: wait `CLKS_PER_BIT/2` cycles (integer division), then sample. A 0 moves to DATA. A 1 is a false start and returns to IDLE with no other effect.
  - DATA: sample every `CLKS_PER_BIT` cycles, 8 bits, LSB first.
  - STOP: sample after `CLKS_PER_BIT` cycles. A 1 accepts the byte. A 0 sets `err`, discards the byte, and leaves the packer untouched. Either way return to IDLE.
- Packer:
  - Holds a byte index 0..WORD_BYTES-1, a shift register, and the current address.
  - On an accepted byte: insert it at the slot for the byte index per `BIG_ENDIAN`, then increment the index.
  - When the index would reach `WORD_BYTES`: assert `writeEnable` with the word and address, clear the index and the shift register, and increment the address modulo 2^ADDR_WIDTH (0xFFF → 0x000).
- Timeout: when `TIMEOUT_CLKS` > 0, an idle counter clears on every accepted byte. If the index ≠ 0 and the counter reaches `TIMEOUT_CLKS`, issue the write with unfilled slots zero and advance the address exactly as for a full word. A flush never occurs with index 0.
- `setAddr`: loads `startAddr`, clears the index, shift register, idle counter and `err`. It does not abort an in-flight RX frame.
- Priority: if `setAddr` and a byte acceptance or flush occur in the same cycle, `setAddr` wins. That byte or word is discarded and no write issues. `byteValid`/`lastByte` still report an accepted byte.
- `err` clears only on `reset` or `setAddr`. `err` does not block further reception.

## Timing
- Reset values: `writeEnable`=0, `writeAddr`=0, `writeData`=0, `lastByte`=0, `byteValid`=0, `err`=0, `busy`=0. FSM is in IDLE, address=0, index=0.
- Reset mid-frame or mid-word aborts everything. No write issues afterwards for the aborted data.
- Byte latency: let T be the stop-bit sample cycle. `byteValid`, `lastByte` and (if the word completes) `writeEnable` are all registered at T+1.
- From the start-bit falling edge at the pin to T: 2 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` cycles, ±1.
- `writeEnable` is high exactly 1 cycle per word. `writeAddr`/`writeData` hold their values until the next write.
- Back-to-back frames: the next start bit is detected starting the cycle after STOP returns to IDLE. No gap beyond one stop bit is required.
- Timeout flush fires on the cycle the counter equals `TIMEOUT_CLKS`. Its write appears one cycle later.

## Test plan
Use `CLKS_PER_BIT`=16 for all scenarios.
- `setAddr` with `startAddr`=0x010, then send DE AD BE EF → single `writeEnable`, `writeAddr`=0x010, `writeData`=0xDEADBEEF. Next word goes to 0x011. Four `byteValid` pulses.
- `BIG_ENDIAN`=0, same bytes → `writeData`=0xEFBEADDE. With `WORD_BYTES`=2 → writes 0xADDE@0, then 0xEFBE@1.
- Frame 0x55 with stop bit 0 → `err`=1, no `byteValid`, index unchanged. Next good byte is accepted. `setAddr` clears `err`.
- `serialIn` low for 4 clocks then high → FSM returns to IDLE, `busy` drops, no `byteValid`, no write.
- `startAddr`=0xFFF, send 8 bytes → writes at 0xFFF then 0x000. Also: `setAddr` in the same cycle as a word completion → no write, address = new `startAddr`.
- `TIMEOUT_CLKS`=100, send 12 34 then idle → write 0x12340000 at the current address. Reset asserted during the 3rd byte of a word → no write, all outputs return to their reset values.
